add_unit: RTL and testbench

- Registered unsigned adder: two WIDTH-bit operands in, one (WIDTH+1)-bit sum out; the sum is never truncated.
- Sits behind the add_if bundle (a, b, sum). It adds a valid/ready handshake on both sides, so it can sit in a pipelined datapath with backpressure.
- Keeps a free-running count of completed results for debug and coverage.

---
 rtl/add_unit.sv | 60 ++++++
 tb/tb_add_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/add_unit.sv
// Registered unsigned adder with valid/ready handshakes on both sides and a
// wrapping count of results taken downstream.
module add_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   sum,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_cnt
);

  // Zero-extend both operands so the carry lands in the top bit.
  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  logic             acc_p0;
  logic             xfer_p0;
  logic [WIDTH:0]   sum_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Stage p0: handshake decode on the input operands.
  assign in_ready = !vld_p1 || out_ready;
  assign acc_p0   = in_valid && in_ready;
  assign xfer_p0  = vld_p1 && out_ready;

  // Stage p1: output register; the sum only loads on accept so idle operands never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      if (acc_p0) begin
        sum_p1 <= add_ext(a, b);
        vld_p1 <= 1'b1;
      end else if (xfer_p0) begin
        vld_p1 <= 1'b0;
      end
      if (xfer_p0)
        cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign sum       = sum_p1;
  assign carry     = sum_p1[WIDTH];
  assign out_valid = vld_p1;
  assign done_cnt  = cnt_p1;

endmodule

// File: tb/tb_add_unit.sv
// Scoreboard bench for add_unit: the driver predicts accepted pairs into a queue,
// a negedge monitor pops and checks each result the DUT hands downstream.
module tb_add_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a, b;
  logic        in_valid, out_ready;
  logic        in_ready, carry, out_valid;
  logic [4:0]  sum;
  logic [15:0] done_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int occ = 0;
  int xfer_cnt = 0;
  int e;

  add_unit #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .carry(carry), .out_valid(out_valid),
    .out_ready(out_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus, issued just after a rising edge.
  task automatic cycle(input int ia, input int ib, input logic iv, input logic ordy);
    logic acc, xf;
    a = 4'(ia); b = 4'(ib); in_valid = iv; out_ready = ordy;
    acc = iv && (occ == 0 || ordy);
    xf  = (occ != 0) && ordy;
    if (acc) exp_q.push_back(ia + ib);
    @(posedge clk); #2;
    occ = acc ? 1 : (xf ? 0 : occ);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), occ);
      chk("in_ready", int'(in_ready), int'(occ == 0 || out_ready));
      chk("done_cnt", int'(done_cnt), xfer_cnt % 65536);
      if (occ != 0) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL sum: got %0d, expected no result pending", sum);
        end else begin
          e = exp_q[0];
          chk("sum", int'(sum), e);
          chk("carry", int'(carry), int'(e[4]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_sum"}, int'(sum), 0);
    chk({tag, "_carry"}, int'(carry), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_done_cnt"}, int'(done_cnt), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk_reset("rst0");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed: streaming, carry boundaries, idle operands.
    cycle(4, 4, 1, 1);
    cycle(5, 6, 1, 1);
    cycle(15, 15, 1, 1);
    cycle(15, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(12, 9, 0, 1);
    cycle(0, 0, 0, 1);

    // Backpressure: 3+2 held while 7+7 waits, then transfer and load together.
    cycle(3, 2, 1, 1);
    cycle(7, 7, 1, 0);
    cycle(7, 7, 1, 0);
    cycle(7, 7, 1, 0);
    cycle(7, 7, 1, 1);
    cycle(0, 0, 0, 1);

    // Reset while a result is stalled downstream.
    cycle(9, 9, 1, 1);
    out_ready = 1'b0; in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    exp_q.delete(); occ = 0; xfer_cnt = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cycle(6, 3, 1, 1);
    cycle(0, 0, 0, 1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle(int'($urandom_range(15)), int'($urandom_range(15)),
            ($urandom % 4) != 0, ($urandom % 3) != 0);

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
